chitchat_rx_monitor: RTL and testbench

Downstream consumer of the chitchat receive wrapper's rx-clock data interface (rx_valid, rx_data0/1, ccrx_frame_drop). It qualifies the incoming frame stream with a link-lock state machine and publishes the last good data pair with a staleness flag. It also keeps saturating good/drop/timeout statistics and inter-frame gap measurements for local-bus readout. All logic runs in the rx_clk domain and sits between the chitchat wrapper and application logic.

---
 rtl/chitchat_rx_monitor_defs.sv | 12 +
 rtl/sat_counter.sv | 20 ++
 rtl/chitchat_rx_monitor.sv | 175 +++++++++++++++++
 tb/tb_chitchat_rx_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/chitchat_rx_monitor_defs.sv
// rtl/chitchat_rx_monitor_defs.sv - shared state encodings and statistics width
package chitchat_rx_monitor_defs;

    localparam int CNT_WI = 16;

    typedef enum logic [1:0] {
        ST_DOWN   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear priority
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/chitchat_rx_monitor.sv
// rtl/chitchat_rx_monitor.sv - link-lock qualifier, data hold and statistics for the chitchat rx stream
module chitchat_rx_monitor
    import chitchat_rx_monitor_defs::*;
#(
    parameter int GAP_WI     = 16,
    parameter int TIMEOUT    = 1024,
    parameter int ACQ_FRAMES = 4,
    parameter int DROP_LIMIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [31:0]       rx_data0,
    input  logic [31:0]       rx_data1,
    input  logic              ccrx_frame_drop,
    input  logic              clear,
    output logic [31:0]       hold_data0,
    output logic [31:0]       hold_data1,
    output logic              hold_valid,
    output logic              link_up,
    output logic              stale,
    output logic [1:0]        state,
    output logic [CNT_WI-1:0] good_cnt,
    output logic [CNT_WI-1:0] drop_cnt,
    output logic [CNT_WI-1:0] timeout_cnt,
    output logic [GAP_WI-1:0] gap_last,
    output logic [GAP_WI-1:0] gap_max
);

    localparam int ACQ_W = $clog2(ACQ_FRAMES + 1);
    localparam int RUN_W = $clog2(DROP_LIMIT + 1);
    localparam logic [ACQ_W-1:0]  ACQ_LAST = ACQ_W'(ACQ_FRAMES);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(DROP_LIMIT);
    localparam logic [ACQ_W-1:0]  ACQ_ONE  = ACQ_W'(1);
    localparam logic [GAP_WI-1:0] GAP_TRIP = GAP_WI'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ACQ_W-1:0]  acq_cnt, acq_cnt_d;
    logic [RUN_W-1:0]  drop_run, drop_run_d;
    logic [GAP_WI-1:0] gap_cnt;
    logic              gap_armed;
    logic              frame;
    logic              timeout_evt;
    logic              publish;
    logic              enter_down;

    // A valid frame coinciding with an upstream drop counts only as a drop.
    assign frame       = rx_valid & ~ccrx_frame_drop;
    assign timeout_evt = ~frame & (gap_cnt == GAP_TRIP);
    assign enter_down  = (state_d == ST_DOWN) && (state_q != ST_DOWN);
    assign state       = state_q;

    always_comb begin
        state_d    = state_q;
        acq_cnt_d  = acq_cnt;
        drop_run_d = drop_run;
        publish    = 1'b0;
        case (state_q)
            ST_DOWN: begin
                if (frame) begin
                    acq_cnt_d = ACQ_ONE;
                    if (ACQ_ONE == ACQ_LAST) begin
                        state_d    = ST_LOCKED;
                        drop_run_d = '0;
                        publish    = 1'b1;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
            end
            ST_ACQ: begin
                if (ccrx_frame_drop || timeout_evt) begin
                    state_d = ST_DOWN;
                end else if (frame) begin
                    acq_cnt_d = acq_cnt + 1'b1;
                    if (acq_cnt_d == ACQ_LAST) begin
                        state_d    = ST_LOCKED;
                        drop_run_d = '0;
                        publish    = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame) begin
                    drop_run_d = '0;
                    publish    = 1'b1;
                end else begin
                    if (ccrx_frame_drop) begin
                        drop_run_d = drop_run + 1'b1;
                    end
                    if ((drop_run_d == RUN_LAST) || timeout_evt) begin
                        state_d = ST_DOWN;
                    end
                end
            end
            default: state_d = ST_DOWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_DOWN;
            acq_cnt    <= '0;
            drop_run   <= '0;
            hold_data0 <= '0;
            hold_data1 <= '0;
            hold_valid <= 1'b0;
            link_up    <= 1'b0;
            stale      <= 1'b1;
            gap_cnt    <= '0;
            gap_armed  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acq_cnt    <= acq_cnt_d;
            drop_run   <= drop_run_d;
            hold_valid <= publish;
            link_up    <= (state_d == ST_LOCKED);
            if (publish) begin
                hold_data0 <= rx_data0;
                hold_data1 <= rx_data1;
                stale      <= 1'b0;
            end else if (enter_down) begin
                stale <= 1'b1;
            end
            if (frame) begin
                gap_cnt <= '0;
            end else if (gap_cnt != '1) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
            if (enter_down || timeout_evt) begin
                gap_armed <= 1'b0;
            end else if (frame) begin
                gap_armed <= 1'b1;
            end
        end
    end

    // The first frame after DOWN or a timeout has no meaningful predecessor.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            gap_last <= '0;
            gap_max  <= '0;
        end else if (frame && gap_armed) begin
            gap_last <= gap_cnt;
            if (gap_cnt > gap_max) begin
                gap_max <= gap_cnt;
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WI)) u_good_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame),
        .clr   (clear),
        .count (good_cnt)
    );

    sat_counter #(.WIDTH(CNT_WI)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ccrx_frame_drop),
        .clr   (clear),
        .count (drop_cnt)
    );

    sat_counter #(.WIDTH(CNT_WI)) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (timeout_evt && (state_q != ST_DOWN)),
        .clr   (clear),
        .count (timeout_cnt)
    );

endmodule

// File: tb/tb_chitchat_rx_monitor.sv
// tb/tb_chitchat_rx_monitor.sv - directed bench with cycle model for chitchat_rx_monitor
module tb_chitchat_rx_monitor;

    localparam int TIMEOUT    = 1024;
    localparam int ACQ_FRAMES = 4;
    localparam int DROP_LIMIT = 2;
    localparam int SAT        = 65535;

    logic        clk = 1'b0;
    logic        rst, rx_valid, ccrx_frame_drop, clear;
    logic [31:0] rx_data0, rx_data1;
    logic [31:0] hold_data0, hold_data1;
    logic        hold_valid, link_up, stale;
    logic [1:0]  state;
    logic [15:0] good_cnt, drop_cnt, timeout_cnt, gap_last, gap_max;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    chitchat_rx_monitor #(
        .GAP_WI(16), .TIMEOUT(TIMEOUT), .ACQ_FRAMES(ACQ_FRAMES), .DROP_LIMIT(DROP_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data0(rx_data0), .rx_data1(rx_data1),
        .ccrx_frame_drop(ccrx_frame_drop), .clear(clear),
        .hold_data0(hold_data0), .hold_data1(hold_data1), .hold_valid(hold_valid),
        .link_up(link_up), .stale(stale), .state(state),
        .good_cnt(good_cnt), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt),
        .gap_last(gap_last), .gap_max(gap_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: idle-run length, lock run and drop run as plain integers.
    int          m_state = 0, m_run = 0, m_drun = 0, m_idle = 0;
    bit          m_armed = 0, m_hv = 0, m_link = 0, m_stale = 1;
    logic [31:0] m_h0 = 0, m_h1 = 0;
    int          m_good = 0, m_drop = 0, m_tmo = 0, m_gl = 0, m_gm = 0;

    always @(posedge clk) begin : model
        bit frm, tmo, pub;
        int prev;
        if (rst) begin
            m_state = 0; m_run = 0; m_drun = 0; m_idle = 0; m_armed = 0;
            m_hv = 0; m_link = 0; m_stale = 1; m_h0 = 0; m_h1 = 0;
            m_good = 0; m_drop = 0; m_tmo = 0; m_gl = 0; m_gm = 0;
        end else begin
            frm  = rx_valid && !ccrx_frame_drop;
            tmo  = !frm && (m_idle == TIMEOUT - 1);
            prev = m_state;
            pub  = 0;
            if (clear) begin
                m_good = 0; m_drop = 0; m_tmo = 0; m_gl = 0; m_gm = 0;
            end else begin
                if (frm && m_good < SAT) m_good++;
                if (ccrx_frame_drop && m_drop < SAT) m_drop++;
                if (tmo && prev != 0 && m_tmo < SAT) m_tmo++;
                if (frm && m_armed) begin
                    m_gl = m_idle;
                    if (m_idle > m_gm) m_gm = m_idle;
                end
            end
            if (prev == 0) begin
                if (frm) begin
                    m_run = 1;
                    m_state = (m_run >= ACQ_FRAMES) ? 2 : 1;
                    pub = (m_state == 2);
                end
            end else if (prev == 1) begin
                if (ccrx_frame_drop || tmo) m_state = 0;
                else if (frm) begin
                    m_run++;
                    if (m_run >= ACQ_FRAMES) begin m_state = 2; pub = 1; end
                end
            end else begin
                if (frm) pub = 1;
                else begin
                    if (ccrx_frame_drop) m_drun++;
                    if (m_drun >= DROP_LIMIT || tmo) m_state = 0;
                end
            end
            if (pub) m_drun = 0;
            if (pub) begin m_h0 = rx_data0; m_h1 = rx_data1; m_stale = 0; end
            m_hv = pub;
            if (m_state == 0 && prev != 0) begin m_stale = 1; m_armed = 0; end
            if (tmo) m_armed = 0;
            if (frm) m_armed = 1;
            m_link = (m_state == 2);
            m_idle = frm ? 0 : ((m_idle < SAT) ? m_idle + 1 : SAT);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_hold_data0", hold_data0, m_h0);
            chk("cmp_hold_data1", hold_data1, m_h1);
            chk("cmp_hold_valid", 32'(hold_valid), 32'(m_hv));
            chk("cmp_link_up", 32'(link_up), 32'(m_link));
            chk("cmp_stale", 32'(stale), 32'(m_stale));
            chk("cmp_state", 32'(state), m_state);
            chk("cmp_good_cnt", 32'(good_cnt), m_good);
            chk("cmp_drop_cnt", 32'(drop_cnt), m_drop);
            chk("cmp_timeout_cnt", 32'(timeout_cnt), m_tmo);
            chk("cmp_gap_last", 32'(gap_last), m_gl);
            chk("cmp_gap_max", 32'(gap_max), m_gm);
        end
    end

    task automatic tick(input bit v, input logic [31:0] d0, input logic [31:0] d1,
                        input bit dr, input bit cl, input bit r);
        rx_valid = v; rx_data0 = d0; rx_data1 = d1;
        ccrx_frame_drop = dr; clear = cl; rst = r;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 0; ccrx_frame_drop = 0; clear = 0; rst = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame(input logic [31:0] d0, input logic [31:0] d1);
        tick(1, d0, d1, 0, 0, 0);
    endtask

    task automatic drop();
        tick(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        rst = 1; rx_valid = 0; ccrx_frame_drop = 0; clear = 0; rx_data0 = 0; rx_data1 = 0;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 1);
        cmp_en = 1;
        chk("rst_state", 32'(state), 0);
        chk("rst_stale", 32'(stale), 1);
        chk("rst_hold_data0", hold_data0, 0);
        chk("rst_good_cnt", 32'(good_cnt), 0);

        // Acquire: four frames ten cycles apart.
        for (int n = 0; n < 4; n++) begin
            frame(32'h1111_0000 + n, 32'h2222_0000 + n);
            if (n == 0) chk("acq_state_first", 32'(state), 1);
            if (n < 3) idle(9);
        end
        chk("lock_hold_valid", 32'(hold_valid), 1);
        chk("lock_hold_data0", hold_data0, 32'h1111_0003);
        chk("lock_link_up", 32'(link_up), 1);
        chk("lock_stale", 32'(stale), 0);
        chk("lock_state", 32'(state), 2);
        chk("lock_gap_last", 32'(gap_last), 9);
        chk("lock_gap_max", 32'(gap_max), 9);
        chk("lock_good_cnt", 32'(good_cnt), 4);

        // Isolated drops keep the lock; two in a row lose it.
        idle(2); drop(); idle(2);
        frame(32'hAAAA_0001, 32'hBBBB_0001);
        drop();
        chk("drop_single_state", 32'(state), 2);
        frame(32'hAAAA_0002, 32'hBBBB_0002);
        drop();
        chk("drop_first_state", 32'(state), 2);
        drop();
        chk("drop_down_state", 32'(state), 0);
        chk("drop_down_stale", 32'(stale), 1);
        chk("drop_down_link", 32'(link_up), 0);
        chk("drop_hold_kept", hold_data0, 32'hAAAA_0002);
        chk("drop_cnt_4", 32'(drop_cnt), 4);

        // Relock with 7-cycle spacing, then let the link time out.
        for (int n = 0; n < 4; n++) begin
            frame(32'h3333_0000 + n, 32'h4444_0000 + n);
            if (n < 3) idle(6);
        end
        chk("relock_gap_last", 32'(gap_last), 6);
        idle(1023);
        chk("tmo_before_state", 32'(state), 2);
        idle(1);
        chk("tmo_state", 32'(state), 0);
        chk("tmo_cnt", 32'(timeout_cnt), 1);
        idle(3000);
        chk("tmo_no_refire", 32'(timeout_cnt), 1);
        frame(32'h5555_0000, 32'h6666_0000);
        chk("tmo_gap_unmeasured", 32'(gap_last), 6);
        chk("tmo_gap_max", 32'(gap_max), 9);
        chk("tmo_acq_state", 32'(state), 1);

        // Valid and drop together in ACQ: drop only.
        tick(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 0);
        chk("both_state", 32'(state), 0);
        chk("both_good_cnt", 32'(good_cnt), 11);
        chk("both_drop_cnt", 32'(drop_cnt), 5);
        chk("both_hold_kept", hold_data0, 32'h3333_0003);

        // Drop counter saturation and clear priority.
        for (int i = 0; i < 65536; i++) drop();
        chk("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
        tick(0, 0, 0, 1, 1, 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 0);
        chk("clr_good_cnt", 32'(good_cnt), 0);
        chk("clr_gap_max", 32'(gap_max), 0);
        chk("clr_stale_kept", 32'(stale), 1);

        // Reset on the locking frame discards it.
        for (int n = 0; n < 3; n++) begin
            frame(32'h7777_0000 + n, 32'h8888_0000 + n);
            idle(2);
        end
        chk("prerst_state", 32'(state), 1);
        tick(1, 32'h7777_0003, 32'h8888_0003, 0, 0, 1);
        chk("rst_mid_hold_valid", 32'(hold_valid), 0);
        chk("rst_mid_state", 32'(state), 0);
        chk("rst_mid_stale", 32'(stale), 1);
        chk("rst_mid_good_cnt", 32'(good_cnt), 0);
        chk("rst_mid_hold_data0", hold_data0, 0);
        idle(2);
        chk("rst_mid_no_late_valid", 32'(hold_valid), 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
